// File: rtl/perceptron_train_seq.sv
// Training sequencer for the 6-bit perceptron core: loads weights, runs epochs, reads weights back.
// Optional PERC_SEQ_EARLY_STOP_EN ends the run after the first zero-error epoch.
module perceptron_train_seq #(
   parameter int unsigned NUM_SAMPLES  = 4,
   parameter int unsigned MAX_EPOCHS   = 15,
   parameter int unsigned DONE_TIMEOUT = 15,
   parameter logic [1:0]  SEL_W0       = 2'd3,
   parameter logic [1:0]  SEL_W1       = 2'd2,
   parameter logic [1:0]  SEL_W2       = 2'd1
) (
   input  logic       clk_i,
   input  logic       reset_l_i,
   input  logic       start_i,
   input  logic       wr_en_i,
   input  logic [2:0] wr_addr_i,
   input  logic [5:0] wr_x1_i,
   input  logic [5:0] wr_x2_i,
   input  logic       wr_label_i,
   input  logic [5:0] cfg_w0_i,
   input  logic [5:0] cfg_w1_i,
   input  logic [5:0] cfg_w2_i,
   input  logic [5:0] cfg_n_i,
   output logic       busy_o,
   output logic       finished_o,
   output logic       converged_o,
   output logic       timeout_err_o,
   output logic [3:0] epoch_count_o,
   output logic [3:0] err_count_o,
   output logic [5:0] w0_q_o,
   output logic [5:0] w1_q_o,
   output logic [5:0] w2_q_o,
   output logic       p_rst_l_o,
   output logic       p_go_o,
   output logic       p_update_o,
   output logic       p_correct_o,
   output logic [1:0] p_sel_out_o,
   output logic [5:0] p_in_val_o,
   input  logic       p_done_i,
   input  logic       p_classification_i,
   input  logic       p_sync_i,
   input  logic [5:0] p_out_val_i
);

   localparam logic [2:0] LastIdx = 3'(NUM_SAMPLES - 1);
   localparam logic [3:0] MaxEp   = 4'(MAX_EPOCHS);
   localparam logic [3:0] TmoLast = 4'(DONE_TIMEOUT - 1);

   typedef enum logic [3:0] {
      StIdle, StPrst, StLdW0, StLdW1, StLdW2, StLdN, StX1, StX2,
      StWait1, StWait2, StCls, StDone, StRbW0, StRbW1, StRbW2, StFin
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] sample_q, sample_d;
   logic [3:0] errs_q, errs_d, ep_errs;
   logic [3:0] tmo_q, tmo_d;
   logic [3:0] epoch_q, epoch_d, err_count_q, err_count_d;
   logic       converged_q, converged_d, timeout_q, timeout_d;
   logic       adv, stop;
   logic [5:0] cfg_w0_q, cfg_w1_q, cfg_w2_q, cfg_n_q;
   logic [5:0] rb_w0_q, rb_w1_q, rb_w2_q;
   logic       busy_q, finished_q, p_rst_l_q, p_go_q, p_update_q, p_correct_q;
   logic [1:0] p_sel_q, sel_d;
   logic [5:0] p_in_val_q, in_val_d;
   logic       go_d, upd_d, correct_d;

   // Sample buffer keeps its contents across reset; writable only while idle.
   logic [5:0] x1_mem [8];
   logic [5:0] x2_mem [8];
   logic [7:0] label_mem;

   always_ff @(posedge clk_i) begin
      if (reset_l_i && state_q == StIdle && wr_en_i && wr_addr_i <= LastIdx) begin
         x1_mem[wr_addr_i]    <= wr_x1_i;
         x2_mem[wr_addr_i]    <= wr_x2_i;
         label_mem[wr_addr_i] <= wr_label_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      errs_d      = errs_q;
      tmo_d       = tmo_q;
      epoch_d     = epoch_q;
      err_count_d = err_count_q;
      converged_d = converged_q;
      timeout_d   = timeout_q;
      adv         = 1'b0;
      stop        = 1'b0;
      ep_errs     = 4'd0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d     = StPrst;
               epoch_d     = 4'd0;
               converged_d = 1'b0;
               timeout_d   = 1'b0;
            end
         end
         StPrst:  state_d = StLdW0;
         StLdW0:  if (p_sync_i) state_d = StLdW1;
         StLdW1:  if (p_sync_i) state_d = StLdW2;
         StLdW2:  if (p_sync_i) state_d = StLdN;
         StLdN: begin
            if (p_sync_i) begin
               state_d  = StX1;
               sample_d = 3'd0;
               errs_d   = 4'd0;
            end
         end
         StX1:    state_d = StX2;
         StX2:    state_d = StWait1;
         StWait1: state_d = StWait2;
         StWait2: state_d = StCls;
         StCls: begin
            if (p_classification_i != label_mem[sample_q]) errs_d = errs_q + 4'd1;
            if (p_done_i) begin
               adv = 1'b1;
            end else begin
               state_d = StDone;
               tmo_d   = 4'd0;
            end
         end
         StDone: begin
            if (p_done_i) begin
               adv = 1'b1;
            end else if (tmo_q == TmoLast) begin
               timeout_d = 1'b1;
               state_d   = StRbW0;
            end else begin
               tmo_d = tmo_q + 4'd1;
            end
         end
         StRbW0:  state_d = StRbW1;
         StRbW1:  state_d = StRbW2;
         StRbW2:  state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (adv) begin
         if (sample_q == LastIdx) begin
            ep_errs     = errs_d;
            err_count_d = ep_errs;
            epoch_d     = epoch_q + 4'd1;
            converged_d = (ep_errs == 4'd0);
            errs_d      = 4'd0;
            sample_d    = 3'd0;
`ifdef PERC_SEQ_EARLY_STOP_EN
            stop = (epoch_d == MaxEp) || (ep_errs == 4'd0);
`else
            stop = (epoch_d == MaxEp);
`endif
            state_d = stop ? StRbW0 : StX1;
         end else begin
            sample_d = sample_q + 3'd1;
            state_d  = StX1;
         end
      end
   end

   // Core-facing outputs are decoded from the next state so they register in step with it.
   always_comb begin
      go_d     = 1'b0;
      in_val_d = 6'd0;
      sel_d    = 2'd0;
      unique case (state_d)
         StLdW0:  begin go_d = 1'b1; in_val_d = cfg_w0_q; end
         StLdW1:  begin go_d = 1'b1; in_val_d = cfg_w1_q; end
         StLdW2:  begin go_d = 1'b1; in_val_d = cfg_w2_q; end
         StLdN:   begin go_d = 1'b1; in_val_d = cfg_n_q; end
         StX1:    begin go_d = 1'b1; in_val_d = x1_mem[sample_d]; end
         StX2:    begin go_d = 1'b1; in_val_d = x2_mem[sample_d]; end
         StRbW0:  sel_d = SEL_W0;
         StRbW1:  sel_d = SEL_W1;
         StRbW2:  sel_d = SEL_W2;
         default: ;
      endcase
      upd_d     = state_d inside {StX1, StX2, StWait1, StWait2, StCls, StDone};
      correct_d = upd_d & label_mem[sample_d];
   end

   always_ff @(posedge clk_i) begin
      if (!reset_l_i) begin
         state_q     <= StIdle;
         sample_q    <= 3'd0;
         errs_q      <= 4'd0;
         tmo_q       <= 4'd0;
         epoch_q     <= 4'd0;
         err_count_q <= 4'd0;
         converged_q <= 1'b0;
         timeout_q   <= 1'b0;
         cfg_w0_q    <= 6'd0;
         cfg_w1_q    <= 6'd0;
         cfg_w2_q    <= 6'd0;
         cfg_n_q     <= 6'd0;
         rb_w0_q     <= 6'd0;
         rb_w1_q     <= 6'd0;
         rb_w2_q     <= 6'd0;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
         p_rst_l_q   <= 1'b0;
         p_go_q      <= 1'b0;
         p_update_q  <= 1'b0;
         p_correct_q <= 1'b0;
         p_sel_q     <= 2'd0;
         p_in_val_q  <= 6'd0;
      end else begin
         state_q     <= state_d;
         sample_q    <= sample_d;
         errs_q      <= errs_d;
         tmo_q       <= tmo_d;
         epoch_q     <= epoch_d;
         err_count_q <= err_count_d;
         converged_q <= converged_d;
         timeout_q   <= timeout_d;
         if (state_q == StIdle && start_i) begin
            cfg_w0_q <= cfg_w0_i;
            cfg_w1_q <= cfg_w1_i;
            cfg_w2_q <= cfg_w2_i;
            cfg_n_q  <= cfg_n_i;
         end
         if (state_q == StRbW0) rb_w0_q <= p_out_val_i;
         if (state_q == StRbW1) rb_w1_q <= p_out_val_i;
         if (state_q == StRbW2) rb_w2_q <= p_out_val_i;
         busy_q      <= (state_d != StIdle) && (state_d != StFin);
         finished_q  <= (state_d == StFin);
         p_rst_l_q   <= (state_d != StPrst);
         p_go_q      <= go_d;
         p_update_q  <= upd_d;
         p_correct_q <= correct_d;
         p_sel_q     <= sel_d;
         p_in_val_q  <= in_val_d;
      end
   end

   assign busy_o        = busy_q;
   assign finished_o    = finished_q;
   assign converged_o   = converged_q;
   assign timeout_err_o = timeout_q;
   assign epoch_count_o = epoch_q;
   assign err_count_o   = err_count_q;
   assign w0_q_o        = rb_w0_q;
   assign w1_q_o        = rb_w1_q;
   assign w2_q_o        = rb_w2_q;
   assign p_rst_l_o     = p_rst_l_q;
   assign p_go_o        = p_go_q;
   assign p_update_o    = p_update_q;
   assign p_correct_o   = p_correct_q;
   assign p_sel_out_o   = p_sel_q;
   assign p_in_val_o    = p_in_val_q;

endmodule

// File: tb/tb_perceptron_train_seq.sv
// Directed bench for perceptron_train_seq with a scripted perceptron core model.
module tb_perceptron_train_seq;

   logic       clk = 1'b0;
   logic       reset_l, start, wr_en, wr_label;
   logic [2:0] wr_addr;
   logic [5:0] wr_x1, wr_x2, cfg_w0, cfg_w1, cfg_w2, cfg_n;
   logic       busy, finished, converged, timeout_err;
   logic [3:0] epoch_count, err_count;
   logic [5:0] w0_q, w1_q, w2_q;
   logic       p_rst_l, p_go, p_update, p_correct;
   logic [1:0] p_sel_out;
   logic [5:0] p_in_val, p_out_val;
   logic       p_done, p_classification, p_sync;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   perceptron_train_seq dut (
      .clk_i(clk), .reset_l_i(reset_l), .start_i(start), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_x1_i(wr_x1), .wr_x2_i(wr_x2), .wr_label_i(wr_label),
      .cfg_w0_i(cfg_w0), .cfg_w1_i(cfg_w1), .cfg_w2_i(cfg_w2), .cfg_n_i(cfg_n),
      .busy_o(busy), .finished_o(finished), .converged_o(converged),
      .timeout_err_o(timeout_err), .epoch_count_o(epoch_count), .err_count_o(err_count),
      .w0_q_o(w0_q), .w1_q_o(w1_q), .w2_q_o(w2_q), .p_rst_l_o(p_rst_l), .p_go_o(p_go),
      .p_update_o(p_update), .p_correct_o(p_correct), .p_sel_out_o(p_sel_out),
      .p_in_val_o(p_in_val), .p_done_i(p_done), .p_classification_i(p_classification),
      .p_sync_i(p_sync), .p_out_val_i(p_out_val)
   );

   // Scripted core: logs accepted values, misclassifies the samples flagged in wrong_tbl
   // (indexed by sample sequence since core reset), raises done done_delay cycles after x2.
   int         ld_cnt = 0;
   int         seq = 0;
   int         done_cnt = 1000;
   int         done_delay = 2;
   logic [5:0] rb_base = 6'h15;
   logic [63:0] wrong_tbl = 64'h25;  // seq 0,2 (epoch 0) and 5 (epoch 1)
   logic [5:0] logq[$];

   always @(posedge clk) begin
      if (p_rst_l !== 1'b1) begin
         ld_cnt   <= 0;
         done_cnt <= 1000;
      end else if (p_go && p_sync) begin
         logq.push_back(p_in_val);
         if (ld_cnt >= 5 && (ld_cnt % 2) == 1) begin
            seq      <= (ld_cnt - 5) / 2;
            done_cnt <= 0;
         end else if (done_cnt < 1000) begin
            done_cnt <= done_cnt + 1;
         end
         ld_cnt <= ld_cnt + 1;
      end else if (done_cnt < 1000) begin
         done_cnt <= done_cnt + 1;
      end
   end

   assign p_done = (done_cnt >= done_delay);
   assign p_classification = p_correct ^ ((seq < 64) ? wrong_tbl[seq[5:0]] : 1'b0);

   always_comb begin
      case (p_sel_out)
         2'd3:    p_out_val = rb_base;
         2'd2:    p_out_val = rb_base ^ 6'h3F;
         2'd1:    p_out_val = rb_base + 6'd1;
         default: p_out_val = 6'd0;
      endcase
   end

`ifdef PERC_SEQ_EARLY_STOP_EN
   localparam int ExpEpochs = 3;
`else
   localparam int ExpEpochs = 15;
`endif

   logic [5:0] bx1 [4];
   logic [5:0] bx2 [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_sample(input logic [2:0] a, input logic [5:0] x1, input logic [5:0] x2,
                               input logic lab);
      wr_en = 1'b1; wr_addr = a; wr_x1 = x1; wr_x2 = x2; wr_label = lab;
      step();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset_l = 1'b0;
      step();
      step();
      checks++;
      if (p_rst_l !== 1'b0) begin
         errors++; $display("FAIL reset_p_rst_l: got %b expected 0", p_rst_l);
      end
      checks++;
      if ({busy, finished, converged, timeout_err, epoch_count, err_count, w0_q, w1_q, w2_q,
           p_go, p_update, p_correct, p_sel_out, p_in_val} !== '0) begin
         errors++; $display("FAIL reset_outputs: busy=%b fin=%b conv=%b to=%b ep=%0d err=%0d go=%b in=%0h",
                            busy, finished, converged, timeout_err, epoch_count, err_count,
                            p_go, p_in_val);
      end
      reset_l = 1'b1;
      step();
      checks++;
      if (p_rst_l !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: p_rst_l=%b busy=%b expected 1/0", p_rst_l, busy);
      end
   endtask

   task automatic test_train();
      int fin_c = -1;
      int bad = 0;
      bx1[0] = 6'd8; bx2[0] = 6'd8; bx1[1] = 6'd0; bx2[1] = 6'd8;
      bx1[2] = 6'd8; bx2[2] = 6'd0; bx1[3] = 6'd0; bx2[3] = 6'd0;
      write_sample(3'd0, bx1[0], bx2[0], 1'b1);
      write_sample(3'd1, bx1[1], bx2[1], 1'b0);
      write_sample(3'd2, bx1[2], bx2[2], 1'b0);
      write_sample(3'd3, bx1[3], bx2[3], 1'b0);
      cfg_w0 = 6'd1; cfg_w1 = 6'd2; cfg_w2 = 6'd3; cfg_n = 6'd8;
      done_delay = 2; p_sync = 1'b1; rb_base = 6'h15;
      logq.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || p_rst_l !== 1'b0 || p_go !== 1'b0) begin
         errors++; $display("FAIL train_prst: busy=%b p_rst_l=%b go=%b expected 1/0/0",
                            busy, p_rst_l, p_go);
      end
      for (int c = 2; c <= 700; c++) begin
         step();
         if (c == 2) begin
            checks++;
            if (p_go !== 1'b1 || p_in_val !== 6'd1) begin
               errors++; $display("FAIL train_ld_w0: go=%b in=%0d expected 1/1", p_go, p_in_val);
            end
         end
         if (c == 6) begin
            checks++;
            if (p_go !== 1'b1 || p_in_val !== 6'd8 || p_update !== 1'b1 || p_correct !== 1'b1) begin
               errors++; $display("FAIL train_first_x1: go=%b in=%0d upd=%b cor=%b expected 1/8/1/1",
                                  p_go, p_in_val, p_update, p_correct);
            end
         end
         if (c == 26) begin
            checks++;
            if (epoch_count !== 4'd1 || err_count !== 4'd2 || converged !== 1'b0) begin
               errors++; $display("FAIL train_epoch1: ep=%0d err=%0d conv=%b expected 1/2/0",
                                  epoch_count, err_count, converged);
            end
         end
         if (c == 46) begin
            checks++;
            if (epoch_count !== 4'd2 || err_count !== 4'd1) begin
               errors++; $display("FAIL train_epoch2: ep=%0d err=%0d expected 2/1",
                                  epoch_count, err_count);
            end
         end
         if (finished === 1'b1) begin
            fin_c = c;
            break;
         end
      end
      checks++;
      if (fin_c !== 9 + 20 * ExpEpochs) begin
         errors++; $display("FAIL train_finish_cycle: got %0d expected %0d", fin_c, 9 + 20 * ExpEpochs);
      end
      checks++;
      if (epoch_count !== 4'(ExpEpochs) || err_count !== 4'd0 || converged !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL train_final: ep=%0d err=%0d conv=%b busy=%b expected %0d/0/1/0",
                            epoch_count, err_count, converged, busy, ExpEpochs);
      end
      checks++;
      if (w0_q !== 6'h15 || w1_q !== 6'h2A || w2_q !== 6'h16) begin
         errors++; $display("FAIL train_readback: w=%0h,%0h,%0h expected 15,2a,16", w0_q, w1_q, w2_q);
      end
      if (logq.size() != 4 + 8 * ExpEpochs) bad++;
      else begin
         if (logq[0] !== 6'd1 || logq[1] !== 6'd2 || logq[2] !== 6'd3 || logq[3] !== 6'd8) bad++;
         for (int k = 0; k < 4 * ExpEpochs; k++) begin
            if (logq[4 + 2 * k] !== bx1[k % 4] || logq[5 + 2 * k] !== bx2[k % 4]) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL train_go_sequence: %0d bad entries, log size %0d expected %0d",
                            bad, logq.size(), 4 + 8 * ExpEpochs);
      end
      step();
   endtask

   task automatic test_timeout_busy();
      logq.delete();
      done_delay = 1000; rb_base = 6'h21;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_x1 = 6'd63; wr_x2 = 6'd63; wr_label = 1'b0;
      step();
      start = 1'b0; wr_en = 1'b0;
      checks++;
      if (p_rst_l !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL busy_ignore_start: p_rst_l=%b busy=%b expected 1/1", p_rst_l, busy);
      end
      repeat (9) step();
      checks++;
      if (timeout_err !== 1'b0 || p_update !== 1'b1) begin
         errors++; $display("FAIL timeout_early: to=%b upd=%b expected 0/1", timeout_err, p_update);
      end
      step();
      checks++;
      if (timeout_err !== 1'b1 || p_sel_out !== 2'd3 || p_go !== 1'b0 || p_update !== 1'b0) begin
         errors++; $display("FAIL timeout_rb_w0: to=%b sel=%0d go=%b upd=%b expected 1/3/0/0",
                            timeout_err, p_sel_out, p_go, p_update);
      end
      step();
      checks++;
      if (p_sel_out !== 2'd2) begin
         errors++; $display("FAIL timeout_rb_w1: sel=%0d expected 2", p_sel_out);
      end
      step();
      checks++;
      if (p_sel_out !== 2'd1 || w0_q !== 6'h21) begin
         errors++; $display("FAIL timeout_rb_w2: sel=%0d w0=%0h expected 1/21", p_sel_out, w0_q);
      end
      step();
      checks++;
      if (finished !== 1'b1 || busy !== 1'b0 || epoch_count !== 4'd0 || w1_q !== 6'h1E ||
          w2_q !== 6'h22) begin
         errors++; $display("FAIL timeout_fin: fin=%b busy=%b ep=%0d w1=%0h w2=%0h expected 1/0/0/1e/22",
                            finished, busy, epoch_count, w1_q, w2_q);
      end
      checks++;
      if (logq.size() != 6) begin
         errors++; $display("FAIL timeout_go_count: got %0d expected 6", logq.size());
      end
      step();
      checks++;
      if (finished !== 1'b0 || timeout_err !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky: fin=%b to=%b expected 0/1", finished, timeout_err);
      end
   endtask

   task automatic test_sync_stall_reset();
      done_delay = 2; p_sync = 1'b1;
      cfg_w0 = 6'h11; cfg_w1 = 6'h2C; cfg_w2 = 6'h05; cfg_n = 6'h09;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL sync_timeout_cleared: got %b expected 0", timeout_err);
      end
      step();
      step();
      p_sync = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) p_sync = 1'b1;
         checks++;
         if (p_go !== 1'b1 || p_in_val !== 6'h2C) begin
            errors++; $display("FAIL sync_hold_w1_%0d: go=%b in=%0h expected 1/2c", k, p_go, p_in_val);
         end
         step();
      end
      checks++;
      if (p_go !== 1'b1 || p_in_val !== 6'h05) begin
         errors++; $display("FAIL sync_ld_w2: go=%b in=%0h expected 1/05", p_go, p_in_val);
      end
      step();
      step();
      checks++;
      if (p_in_val !== 6'd8) begin
         errors++; $display("FAIL buffer_unchanged_x1: got %0d expected 8", p_in_val);
      end
      step();
      step();
      checks++;
      if (p_go !== 1'b0 || p_update !== 1'b1) begin
         errors++; $display("FAIL sync_wait1: go=%b upd=%b expected 0/1", p_go, p_update);
      end
      reset_l = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || p_go !== 1'b0 || p_rst_l !== 1'b0) begin
         errors++; $display("FAIL midrun_reset: busy=%b go=%b p_rst_l=%b expected 0/0/0",
                            busy, p_go, p_rst_l);
      end
      reset_l = 1'b1;
      step();
      start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_x1 = 6'd5; wr_x2 = 6'd9; wr_label = 1'b1;
      step();
      start = 1'b0; wr_en = 1'b0;
      checks++;
      if (p_rst_l !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL restart_prst: p_rst_l=%b busy=%b expected 0/1", p_rst_l, busy);
      end
      step();
      checks++;
      if (p_go !== 1'b1 || p_in_val !== 6'h11) begin
         errors++; $display("FAIL restart_ld_w0: go=%b in=%0h expected 1/11", p_go, p_in_val);
      end
      repeat (4) step();
      checks++;
      if (p_in_val !== 6'd5 || p_correct !== 1'b1) begin
         errors++; $display("FAIL write_with_start_x1: in=%0d cor=%b expected 5/1", p_in_val, p_correct);
      end
      step();
      checks++;
      if (p_in_val !== 6'd9) begin
         errors++; $display("FAIL write_with_start_x2: got %0d expected 9", p_in_val);
      end
      reset_l = 1'b0;
      step();
      reset_l = 1'b1;
      step();
   endtask

   task automatic test_late_done();
      int fin_c = -1;
      done_delay = 5;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 700; c++) begin
         step();
         if (finished === 1'b1) begin
            fin_c = c;
            break;
         end
      end
      checks++;
      if (fin_c !== 9 + 32 * ExpEpochs) begin
         errors++; $display("FAIL late_done_cycle: got %0d expected %0d", fin_c, 9 + 32 * ExpEpochs);
      end
      checks++;
      if (epoch_count !== 4'(ExpEpochs) || timeout_err !== 1'b0 || converged !== 1'b1) begin
         errors++; $display("FAIL late_done_final: ep=%0d to=%b conv=%b expected %0d/0/1",
                            epoch_count, timeout_err, converged, ExpEpochs);
      end
      step();
   endtask

   initial begin
      reset_l = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_x1 = 6'd0; wr_x2 = 6'd0;
      wr_label = 1'b0; cfg_w0 = 6'd0; cfg_w1 = 6'd0; cfg_w2 = 6'd0; cfg_n = 6'd0; p_sync = 1'b1;
      test_reset();
      test_train();
      test_timeout_busy();
      test_sync_stall_reset();
      test_late_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
